// File: rtl/mole_spawner.sv
// mole_spawner: pseudo-random mole source with round timing, score/miss tracking and game-over.
module mole_spawner #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES = 25_000_000,
  parameter int MAX_MISSES = 3,
  parameter int SCORE_W = 8,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit,
  output logic [1:0]         num,
  output logic               mole_up,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               game_over
);
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(MAXC) < 1 ? 1 : $clog2(MAXC);
  typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [7:0] lfsr;
  logic [1:0] pos;
  logic [3:0] miss_next;
  logic gap_done, timeout, scored, missed;
  always_comb begin
    pos = lfsr[1:0] == num ? lfsr[1:0] + 2'd1 : lfsr[1:0];
    gap_done = timer == TW'(GAP_CYCLES - 1);
    timeout = timer == TW'(HOLD_CYCLES - 1);
    miss_next = misses + 4'd1;
    scored = state == UP && hit;
    missed = state == UP && !hit && timeout;
    state_n = start ? GAP
            : state == GAP && gap_done ? UP
            : scored ? GAP
            : missed ? (miss_next == 4'(MAX_MISSES) ? OVER : GAP)
            : state;
  end
  assign mole_up = state == UP;
  assign game_over = state == OVER;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr <= SEED;
      timer <= '0;
      num <= '0;
      score <= '0;
      misses <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      state <= state_n;
      // start restarts the timer even when the state stays GAP
      timer <= (start || state_n != state || state == IDLE || state == OVER) ? '0 : timer + 1'b1;
      num <= (!start && state == GAP && gap_done) ? pos : num;
      score <= start ? '0 : (scored && score != '1) ? score + 1'b1 : score;
      misses <= start ? '0 : missed ? miss_next : misses;
    end
  end
endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner: directed scenario tests with an independent LFSR model for hole selection.
module tb_mole_spawner;
  logic clk = 0, rst_n = 0, start = 0, hit = 0;
  logic [1:0] num;
  logic mole_up, game_over;
  logic [7:0] score;
  logic [3:0] misses;
  int n_cmp = 0, n_err = 0;
  logic [7:0] m_lf, m_lf_q;

  mole_spawner #(.HOLD_CYCLES(8), .GAP_CYCLES(4), .MAX_MISSES(3), .SCORE_W(8), .SEED(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .num(num), .mole_up(mole_up),
    .score(score), .misses(misses), .game_over(game_over));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_lf <= 8'hA5;
      m_lf_q <= 8'hA5;
    end else begin
      m_lf_q <= m_lf;
      m_lf <= {m_lf[6:0], m_lf[7] ^ m_lf[5] ^ m_lf[4] ^ m_lf[3]};
    end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 0; start = 0; hit = 0;
    tick(2);
    rst_n = 1;
    tick(1);
  endtask

  task automatic pulse_start;
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if ({mole_up, game_over, score, misses, num} !== 16'h0) begin n_err++;
      $display("FAIL reset_idle: got up=%b over=%b score=%0d misses=%0d num=%0d, want all 0", mole_up, game_over, score, misses, num); end
    pulse_start; tick(4);
    hit = 1; tick(1); hit = 0;
    tick(4);
    n_cmp++; if (mole_up !== 1'b1 || score !== 8'd1) begin n_err++;
      $display("FAIL reset_setup: got up=%b score=%0d, want up=1 score=1", mole_up, score); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({mole_up, game_over, score, misses, num} !== 16'h0) begin n_err++;
      $display("FAIL reset_async: got up=%b over=%b score=%0d misses=%0d num=%0d, want all 0", mole_up, game_over, score, misses, num); end
    tick(1); rst_n = 1; tick(1);
  endtask

  task automatic run_miss_rounds(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      tick(3);
      n_cmp++; if (mole_up !== 1'b0) begin n_err++;
        $display("FAIL miss_gap r%0d: got mole_up=%b, want 0", r, mole_up); end
      tick(1);
      n_cmp++; if (mole_up !== 1'b1) begin n_err++;
        $display("FAIL miss_rise r%0d: got mole_up=%b, want 1", r, mole_up); end
      tick(7);
      n_cmp++; if (mole_up !== 1'b1) begin n_err++;
        $display("FAIL miss_hold r%0d: got mole_up=%b, want 1", r, mole_up); end
      tick(1);
      n_cmp++; if (mole_up !== 1'b0 || misses !== 4'(r) || game_over !== (r == 3)) begin n_err++;
        $display("FAIL miss_end r%0d: got up=%b misses=%0d over=%b, want up=0 misses=%0d over=%b", r, mole_up, misses, game_over, r, r == 3); end
    end
  endtask

  task automatic test_timeout;
    do_reset;
    pulse_start;
    run_miss_rounds(1, 3);
    hit = 1; tick(3); hit = 0;
    n_cmp++; if (score !== 8'd0 || misses !== 4'd3 || game_over !== 1'b1 || mole_up !== 1'b0) begin n_err++;
      $display("FAIL over_hit: got score=%0d misses=%0d over=%b up=%b, want 0/3/1/0", score, misses, game_over, mole_up); end
  endtask

  task automatic test_hit;
    do_reset;
    pulse_start; tick(4);
    tick(2);
    hit = 1; tick(1);
    n_cmp++; if (mole_up !== 1'b0 || score !== 8'd1) begin n_err++;
      $display("FAIL hit_third: got up=%b score=%0d, want up=0 score=1", mole_up, score); end
    tick(1); hit = 0;
    n_cmp++; if (score !== 8'd1) begin n_err++;
      $display("FAIL hit_stale: got score=%0d, want 1", score); end
    tick(2);
    n_cmp++; if (mole_up !== 1'b0) begin n_err++;
      $display("FAIL hit_gap: got mole_up=%b, want 0", mole_up); end
    tick(1);
    n_cmp++; if (mole_up !== 1'b1) begin n_err++;
      $display("FAIL hit_next_rise: got mole_up=%b, want 1", mole_up); end
  endtask

  task automatic test_hit_timeout;
    tick(7);
    hit = 1; tick(1); hit = 0;
    n_cmp++; if (mole_up !== 1'b0 || score !== 8'd2 || misses !== 4'd0) begin n_err++;
      $display("FAIL hit_last: got up=%b score=%0d misses=%0d, want 0/2/0", mole_up, score, misses); end
    hit = 1; tick(3); hit = 0;
    n_cmp++; if (score !== 8'd2 || mole_up !== 1'b0) begin n_err++;
      $display("FAIL gap_hit: got score=%0d up=%b, want score=2 up=0", score, mole_up); end
    tick(1);
    n_cmp++; if (mole_up !== 1'b1) begin n_err++;
      $display("FAIL gap_hit_rise: got mole_up=%b, want 1", mole_up); end
  endtask

  task automatic test_start;
    tick(2);
    start = 1; hit = 1; tick(1); start = 0; hit = 0;
    n_cmp++; if (mole_up !== 1'b0 || score !== 8'd0 || misses !== 4'd0) begin n_err++;
      $display("FAIL start_up: got up=%b score=%0d misses=%0d, want 0/0/0", mole_up, score, misses); end
    run_miss_rounds(1, 3);
    pulse_start;
    n_cmp++; if (game_over !== 1'b0 || score !== 8'd0 || misses !== 4'd0 || mole_up !== 1'b0) begin n_err++;
      $display("FAIL start_over: got over=%b score=%0d misses=%0d up=%b, want all 0", game_over, score, misses, mole_up); end
    tick(4);
    n_cmp++; if (mole_up !== 1'b1) begin n_err++;
      $display("FAIL start_over_rise: got mole_up=%b, want 1", mole_up); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] prev, exp;
    int w;
    do_reset;
    prev = 2'd0;
    pulse_start;
    for (int r = 1; r <= 260; r++) begin
      w = 0;
      while (!mole_up && w < 10) begin tick(1); w++; end
      n_cmp++; if (mole_up !== 1'b1) begin n_err++;
        $display("FAIL b2b_rise r%0d: mole never rose within 10 cycles", r); end
      exp = (m_lf_q[1:0] == prev) ? m_lf_q[1:0] + 2'd1 : m_lf_q[1:0];
      n_cmp++; if (num !== exp || num === prev) begin n_err++;
        $display("FAIL b2b_num r%0d: got num=%0d, want %0d (prev %0d)", r, num, exp, prev); end
      prev = exp;
      hit = 1; tick(1); hit = 0;
      n_cmp++; if (score !== 8'(r > 255 ? 255 : r)) begin n_err++;
        $display("FAIL b2b_score r%0d: got score=%0d, want %0d", r, score, r > 255 ? 255 : r); end
    end
  endtask

  initial begin
    test_reset;
    test_timeout;
    test_hit;
    test_hit_timeout;
    test_start;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
